// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a 64x16 registered-read data memory.
// Accepts one request at a time, forms base + sign-extended offset,
// range-checks it, strobes the memory and returns a registered response.
module lsu_mem_ctrl #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 6,
   parameter int ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [DATA_W-1:0]   req_base,
   input  logic [ADDR_W-1:0]   req_offset,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                mem_wr_en,
   output logic                mem_rd_en,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W-1:0]   mem_data_in,
   input  logic [DATA_W-1:0]   mem_data_out,
   output logic [ERRCNT_W-1:0] err_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                state, state_nxt;
   logic                  is_load, is_load_nxt;
   logic                  req_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
   logic                  wr_en_nxt, rd_en_nxt;
   logic [DATA_W-1:0]     rsp_rdata_nxt, data_in_nxt;
   logic [ADDR_W-1:0]     address_nxt;
   logic [ERRCNT_W-1:0]   err_count_nxt;

   logic signed [DATA_W-1:0] offset_ext;
   logic [DATA_W-1:0]        ea;
   logic                     ea_oor;

   // Counter that sticks at all-ones instead of wrapping.
   function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] c);
      return (&c) ? c : c + ERRCNT_W'(1);
   endfunction

   // The offset is a signed immediate; the sum wraps modulo 2^DATA_W.
   assign offset_ext = signed'({{(DATA_W-ADDR_W){req_offset[ADDR_W-1]}}, req_offset});
   assign ea         = req_base + offset_ext;
   assign ea_oor     = |ea[DATA_W-1:ADDR_W];

   // Register state and every output; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         is_load     <= 1'b0;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         mem_wr_en   <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_address <= '0;
         mem_data_in <= '0;
         err_count   <= '0;
      end else begin
         state       <= state_nxt;
         is_load     <= is_load_nxt;
         req_ready   <= req_ready_nxt;
         rsp_valid   <= rsp_valid_nxt;
         rsp_rdata   <= rsp_rdata_nxt;
         rsp_err     <= rsp_err_nxt;
         mem_wr_en   <= wr_en_nxt;
         mem_rd_en   <= rd_en_nxt;
         mem_address <= address_nxt;
         mem_data_in <= data_in_nxt;
         err_count   <= err_count_nxt;
      end
   end

   // Next-state and next-output logic; everything holds unless a state acts on it.
   always_comb begin
      state_nxt     = state;
      is_load_nxt   = is_load;
      rsp_valid_nxt = rsp_valid;
      rsp_rdata_nxt = rsp_rdata;
      rsp_err_nxt   = rsp_err;
      wr_en_nxt     = mem_wr_en;
      rd_en_nxt     = mem_rd_en;
      address_nxt   = mem_address;
      data_in_nxt   = mem_data_in;
      err_count_nxt = err_count;

      case (state)
         IDLE: begin
            if (req_valid) begin
               if (ea_oor) begin
                  state_nxt     = RESP;
                  rsp_valid_nxt = 1'b1;
                  rsp_err_nxt   = 1'b1;
                  rsp_rdata_nxt = '0;
                  err_count_nxt = sat_inc(err_count);
               end else begin
                  state_nxt   = ISSUE;
                  is_load_nxt = ~req_we;
                  wr_en_nxt   = req_we;
                  rd_en_nxt   = ~req_we;
                  address_nxt = ea[ADDR_W-1:0];
                  if (req_we) data_in_nxt = req_wdata;
               end
            end
         end
         ISSUE: begin
            // Memory has sampled the strobes; drop them so each is one cycle.
            wr_en_nxt = 1'b0;
            rd_en_nxt = 1'b0;
            if (is_load) begin
               state_nxt = WAIT;
            end else begin
               state_nxt     = RESP;
               rsp_valid_nxt = 1'b1;
               rsp_rdata_nxt = '0;
               rsp_err_nxt   = 1'b0;
            end
         end
         WAIT: begin
            state_nxt     = RESP;
            rsp_valid_nxt = 1'b1;
            rsp_rdata_nxt = mem_data_out;
            rsp_err_nxt   = 1'b0;
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt     = IDLE;
               rsp_valid_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      req_ready_nxt = (state_nxt == IDLE);
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl with a behavioural 64x16 memory.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [15:0] req_base, req_wdata;
   logic [5:0]  req_offset;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [15:0] rsp_rdata;
   logic        mem_wr_en, mem_rd_en;
   logic [5:0]  mem_address;
   logic [15:0] mem_data_in, mem_data_out;
   logic [7:0]  err_count;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] ref_mem [64];
   logic [15:0] mem_arr [64];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          exp_err  = 0;

   lsu_mem_ctrl #(.DATA_W(16), .ADDR_W(6), .ERRCNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
      .mem_address(mem_address), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Data memory with registered read; contents clear on reset.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) mem_arr[i] <= '0;
         mem_data_out <= '0;
      end else begin
         if (mem_wr_en) mem_arr[mem_address] <= mem_data_in;
         if (mem_rd_en) mem_data_out <= mem_arr[mem_address];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 1);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
      check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
      check({tag, "_rsp_err"},   32'(rsp_err),   0);
      check({tag, "_wr_en"},     32'(mem_wr_en), 0);
      check({tag, "_rd_en"},     32'(mem_rd_en), 0);
      check({tag, "_address"},   32'(mem_address), 0);
      check({tag, "_data_in"},   32'(mem_data_in), 0);
      check({tag, "_err_count"}, 32'(err_count), 0);
   endtask

   // One request: predict result, drive, watch strobes, compare response, handshake.
   task automatic do_req(input logic we, input logic [15:0] base, input logic [5:0] off,
                         input logic [15:0] wdata, input int hold);
      exp_t        e;
      logic [15:0] ea;
      logic        err;
      int          lat, nwr, nrd;
      logic        both, addr_ok;
      ea  = base + {{10{off[5]}}, off};
      err = (ea[15:6] != 10'd0);
      e.err   = err;
      e.lat   = err ? 1 : (we ? 2 : 3);
      e.rdata = (err || we) ? 16'h0000 : ref_mem[ea[5:0]];
      if (!err && we) ref_mem[ea[5:0]] = wdata;
      if (err && exp_err != 255) exp_err++;
      sb.push_back(e);

      check("ready_idle", 32'(req_ready), 1);
      req_valid = 1'b1; req_we = we; req_base = base; req_offset = off; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = ~we; req_base = 16'h0123; req_offset = 6'h2A; req_wdata = 16'hDEAD;
      check("ready_busy", 32'(req_ready), 0);

      lat = 1; nwr = 0; nrd = 0; both = 1'b0; addr_ok = 1'b1;
      while (!rsp_valid && lat < 12) begin
         if (mem_wr_en) begin
            nwr++;
            if (mem_address != ea[5:0] || mem_data_in != wdata) addr_ok = 1'b0;
         end
         if (mem_rd_en) begin
            nrd++;
            if (mem_address != ea[5:0]) addr_ok = 1'b0;
         end
         if (mem_wr_en && mem_rd_en) both = 1'b1;
         @(posedge clk); #1;
         lat++;
      end

      e = sb.pop_front();
      if (!rsp_valid) begin
         check("rsp_timeout", 0, 1);
      end else begin
         check("latency",   32'(lat), 32'(e.lat));
         check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
         check("rsp_err",   32'(rsp_err), 32'(e.err));
         check("wr_pulses", 32'(nwr), (!err && we) ? 1 : 0);
         check("rd_pulses", 32'(nrd), (!err && !we) ? 1 : 0);
         check("strobe_excl", 32'(both), 0);
         check("strobe_addr", 32'(addr_ok), 1);
         check("strobes_idle", 32'({mem_wr_en, mem_rd_en}), 0);
         check("err_count", 32'(err_count), 32'(exp_err));
      end

      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", 32'(rsp_valid), 1);
         check("hold_rdata", 32'(rsp_rdata), 32'(e.rdata));
         check("hold_ready", 32'(req_ready), 0);
      end

      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("rsp_drop", 32'(rsp_valid), 0);
      check("ready_back", 32'(req_ready), 1);
   endtask

   // Global bound so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) ref_mem[i] = 16'h0000;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_base = '0;
      req_offset = '0; req_wdata = '0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Store then load to the same word via different base/offset.
      do_req(1'b1, 16'h0010, 6'd3,        16'hBEEF, 0);
      do_req(1'b0, 16'h0015, 6'b111110,   16'h0000, 5);
      // Out of range, and the wrap-around to address 0.
      do_req(1'b0, 16'h0040, 6'd0,        16'h0000, 0);
      do_req(1'b1, 16'hFFFF, 6'd1,        16'h1234, 0);
      do_req(1'b0, 16'hFFFF, 6'd1,        16'h0000, 0);
      // Edges of the range: top word valid, one past it faults.
      do_req(1'b1, 16'h003F, 6'd0,        16'hA5C3, 0);
      do_req(1'b0, 16'h0040, 6'b111111,   16'h0000, 0);
      do_req(1'b0, 16'h003F, 6'd1,        16'h0000, 0);

      // Reset while waiting on the memory read.
      req_valid = 1'b1; req_we = 1'b0; req_base = 16'h0013; req_offset = 6'd0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 64; i++) ref_mem[i] = 16'h0000;
      exp_err = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("no_rsp_after_rst", 32'(rsp_valid), 0);
      end
      do_req(1'b0, 16'h0013, 6'd0, 16'h0000, 0);

      // Drive the error counter past saturation.
      for (int i = 0; i < 260; i++)
         do_req(i[0], 16'h0100 + 16'(i), 6'd0, 16'h0000, 0);
      check("err_sat", 32'(err_count), 32'hFF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
